// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared types and constants for the instruction-fetch prefetch queue
// Contents: instruction width, PC increment, NOP encoding and the queue entry type.
package if_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: handshake/bus bundle of the fetch front end
// master: the prefetch queue (drives imem address and out_* head signals, queue_count)
// slave : its environment (drives imem read data, redirect request and the ID stall)
interface if_prefetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    import if_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0]  imem_address;
    logic [INSTR_W-1:0] imem_instruction;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               stall;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instruction;
    logic [31:0]        out_pc;
    logic [31:0]        out_pc_plus_4;
    logic [CW-1:0]      queue_count;
    modport master (
        output imem_address, out_valid, out_instruction, out_pc, out_pc_plus_4, queue_count,
        input  imem_instruction, redirect_valid, redirect_pc, stall
    );
    modport slave (
        input  imem_address, out_valid, out_instruction, out_pc, out_pc_plus_4, queue_count,
        output imem_instruction, redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/if_prefetch_queue_entry_fifo.sv
// if_entry_fifo: synchronous FIFO of fetch entries with single-cycle flush
// Ports: clk, reset (sync, active-low), push/pop/flush controls, wr_data in,
//        rd_data = head entry (valid only when count != 0), count = occupancy.
// The caller never pushes when full without a pop, nor pops when empty.
module if_entry_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_data,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wr_data;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage is not reset: an empty count already hides stale entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end
    assign rd_data = mem_q[head_q];
    assign count   = count_q;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with a small prefetch FIFO
// Ports: clk, reset (sync, active-low), bus (if_prefetch_queue_if.master):
//   imem_address/imem_instruction to instruction memory, redirect_valid/redirect_pc
//   from ID, stall from ID, out_* head entry (NOP-gated) and queue_count.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    if_prefetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    logic          valid, push, pop;
    fetch_entry_t  head;
    assign valid = count != '0;
    // Redirect overrides everything; a full queue may still accept when the head leaves.
    assign pop  = valid & ~bus.stall & ~bus.redirect_valid;
    assign push = ~bus.redirect_valid & ((count < CW'(DEPTH)) | pop);
    always_comb begin
        fetch_pc_d = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) :
                     push               ? fetch_pc_q + PC_STEP      :
                                          fetch_pc_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end
    if_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect_valid),
        .wr_data ('{pc: fetch_pc_q, instr: bus.imem_instruction}),
        .rd_data (head),
        .count   (count)
    );
    // Outputs depend only on registered queue state, never on stall or redirect.
    assign bus.imem_address    = fetch_pc_q[ADDR_W-1:0];
    assign bus.out_valid       = valid;
    assign bus.out_instruction = valid ? head.instr : NOP_INSTR;
    assign bus.out_pc          = valid ? head.pc : 32'h0;
    assign bus.out_pc_plus_4   = valid ? head.pc + PC_STEP : 32'h0;
    assign bus.queue_count     = count;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: self-checking bench with a queue-based reference model
module tb_if_prefetch_queue;
    import if_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int   n_run = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    if_prefetch_queue_if #(.DEPTH(4), .ADDR_W(8)) ifa ();
    if_prefetch_queue_if #(.DEPTH(4), .ADDR_W(8)) ifb ();
    function automatic logic [31:0] imem_word(input logic [7:0] a);
        return 32'h1357_0000 + {24'h0, a};
    endfunction
    assign ifa.imem_instruction = imem_word(ifa.imem_address);
    assign ifb.imem_instruction = imem_word(ifb.imem_address);
    assign ifb.stall            = 1'b0;
    assign ifb.redirect_valid   = 1'b0;
    assign ifb.redirect_pc      = 32'h0;
    if_prefetch_queue #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master));
    if_prefetch_queue #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: a plain queue of {pc, instr} plus the fetch PC.
    fetch_entry_t mq[$];
    logic [31:0]  m_pc = 32'h0;
    bit           m_pop, m_push;
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_pc = 32'h0;
        end else if (ifa.redirect_valid) begin
            mq.delete();
            m_pc = {ifa.redirect_pc[31:2], 2'b00};
        end else begin
            m_pop  = mq.size() != 0 && !ifa.stall;
            m_push = mq.size() < 4 || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{pc: m_pc, instr: imem_word(m_pc[7:0])});
                m_pc = m_pc + 32'd4;
            end
        end
    end
    always @(negedge clk) begin
        chk("m_valid", {31'h0, ifa.out_valid}, {31'h0, mq.size() != 0});
        chk("m_instr", ifa.out_instruction, mq.size() != 0 ? mq[0].instr : 32'h0);
        chk("m_pc", ifa.out_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
        chk("m_pc4", ifa.out_pc_plus_4, mq.size() != 0 ? mq[0].pc + 32'd4 : 32'h0);
        chk("m_count", {29'h0, ifa.queue_count}, mq.size());
        chk("m_addr", {24'h0, ifa.imem_address}, {24'h0, m_pc[7:0]});
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b0;
        ifa.stall = 1'b0;
        ifa.redirect_valid = 1'b0;
        ifa.redirect_pc = 32'h0;
        repeat (3) cyc();
        reset = 1'b1;
        chk("rst_valid", {31'h0, ifa.out_valid}, 32'h0);
        chk("rst_instr", ifa.out_instruction, 32'h0);
        chk("rst_pc", ifa.out_pc, 32'h0);
        chk("rst_pc4", ifa.out_pc_plus_4, 32'h0);
        chk("rst_count", {29'h0, ifa.queue_count}, 32'h0);
        chk("rst_addr", {24'h0, ifa.imem_address}, 32'h0);
        chk("b_rst_addr", {24'h0, ifb.imem_address}, 32'hF8);
        cyc();
        chk("free_valid", {31'h0, ifa.out_valid}, 32'h1);
        chk("free_pc0", ifa.out_pc, 32'h0);
        chk("free_pc4_0", ifa.out_pc_plus_4, 32'h4);
        chk("free_instr0", ifa.out_instruction, 32'h1357_0000);
        chk("wrap_pc0", ifb.out_pc, 32'hFFFF_FFF8);
        chk("wrap_addr1", {24'h0, ifb.imem_address}, 32'hFC);
        cyc();
        chk("free_pc1", ifa.out_pc, 32'h4);
        chk("wrap_pc1", ifb.out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", ifb.out_pc_plus_4, 32'h0);
        chk("wrap_addr2", {24'h0, ifb.imem_address}, 32'h00);
        cyc();
        chk("free_pc2", ifa.out_pc, 32'h8);
        chk("wrap_pc2", ifb.out_pc, 32'h0);
        cyc();
        chk("free_pc3", ifa.out_pc, 32'hC);
        ifa.stall = 1'b1;
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        chk("fill_count0", {29'h0, ifa.queue_count}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("fill_count", {29'h0, ifa.queue_count}, k);
            chk("fill_pc", ifa.out_pc, 32'h0);
        end
        cyc();
        chk("full_hold_count", {29'h0, ifa.queue_count}, 32'h4);
        chk("full_hold_addr", {24'h0, ifa.imem_address}, 32'h10);
        chk("model_fetch_pc", m_pc, 32'h10);
        ifa.stall = 1'b0;
        cyc();
        ifa.stall = 1'b1;
        chk("fullpop_count", {29'h0, ifa.queue_count}, 32'h4);
        chk("fullpop_addr", {24'h0, ifa.imem_address}, 32'h14);
        chk("fullpop_pc", ifa.out_pc, 32'h4);
        cyc();
        chk("stall_stable_pc", ifa.out_pc, 32'h4);
        ifa.stall = 1'b0;
        cyc();
        chk("drain_pc8", ifa.out_pc, 32'h8);
        cyc();
        chk("drain_pc12", ifa.out_pc, 32'hC);
        for (int s = 0; s < 2; s++) begin
            ifa.stall = (s == 1);
            ifa.redirect_valid = 1'b1;
            ifa.redirect_pc = 32'h0000_0043;
            cyc();
            ifa.redirect_valid = 1'b0;
            chk("redir_count", {29'h0, ifa.queue_count}, 32'h0);
            chk("redir_valid", {31'h0, ifa.out_valid}, 32'h0);
            chk("redir_instr", ifa.out_instruction, 32'h0);
            chk("redir_addr", {24'h0, ifa.imem_address}, 32'h40);
            cyc();
            chk("redir_pc", ifa.out_pc, 32'h40);
            chk("redir_tgt_instr", ifa.out_instruction, 32'h1357_0040);
        end
        ifa.stall = 1'b0;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc = 32'h80;
        cyc();
        ifa.redirect_pc = 32'h101;
        cyc();
        ifa.redirect_valid = 1'b0;
        chk("b2b_addr", {24'h0, ifa.imem_address}, 32'h00);
        chk("b2b_count", {29'h0, ifa.queue_count}, 32'h0);
        cyc();
        chk("b2b_pc", ifa.out_pc, 32'h100);
        ifa.stall = 1'b1;
        ifa.redirect_valid = 1'b1;
        ifa.redirect_pc = 32'h20;
        cyc();
        ifa.redirect_valid = 1'b0;
        repeat (3) cyc();
        chk("mid_count3", {29'h0, ifa.queue_count}, 32'h3);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("mid_rst_count", {29'h0, ifa.queue_count}, 32'h0);
        chk("mid_rst_valid", {31'h0, ifa.out_valid}, 32'h0);
        chk("mid_rst_addr", {24'h0, ifa.imem_address}, 32'h0);
        ifa.stall = 1'b0;
        cyc();
        chk("mid_first_pc", ifa.out_pc, 32'h0);
        chk("mid_first_valid", {31'h0, ifa.out_valid}, 32'h1);
        repeat (4) cyc();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end between instruction_memory and if_id_reg.
- Owns the fetch PC and drives the instruction memory address.
- Buffers fetched instructions with their PCs in a small FIFO so an ID-stage stall does not stop fetching.
- Flushes and redirects on a taken branch (PCSrc) from downstream.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- ADDR_W, 8, instruction memory byte-address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- imem_address  out  ADDR_W  byte address to instruction_memory; equals fetch_pc[ADDR_W-1:0].
- imem_instruction  in  32  combinational read data for imem_address, same cycle.
- redirect_valid  in  1  taken branch or flush request from ID.
- redirect_pc  in  32  branch target; bits [1:0] ignored.
- stall  in  1  1 = ID not consuming this cycle (hazard or IF_ID_Enable low).
- out_valid  out  1  queue head holds a valid instruction.
- out_instruction  out  32  head instruction; 32'h0 (NOP) when out_valid=0.
- out_pc  out  32  PC of the head instruction; 0 when out_valid=0.
- out_pc_plus_4  out  32  out_pc + 4, modulo 2^32; 0 when out_valid=0.
- queue_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0 at a rising edge): fetch_pc=RESET_PC, head=tail=count=0.
  - Outputs: out_valid=0, out_instruction=0, out_pc=0, out_pc_plus_4=0, queue_count=0.
  - Reset mid-operation discards all entries, with no partial state.
- Pop: pop = out_valid & ~stall & ~redirect_valid. The head advances at the edge.
- Push: push = ~redirect_valid & (count<DEPTH | pop).
  - Writes {fetch_pc, imem_instruction} at tail.
  - fetch_pc += 4 at the same edge.
- Full queue with a pop: push and pop occur together; count stays DEPTH.
- Full queue without a pop: no push; fetch_pc holds and imem_address is stable.
- Empty queue with a push: the entry is visible on the outputs the next cycle, giving 1-cycle fetch-to-output latency.
  - No bypass from imem to the outputs.
- Push only: count+1. Pop only: count-1. Both: count unchanged.
- redirect_valid=1 (priority over stall, push and pop):
  - At the edge: count=0, head=tail=0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Next cycle: fetches from the target, out_valid=0.
  - Cycle after that: target instruction at the head.
  - Redirect-to-output latency is 2 cycles.
- Back-to-back redirects: the last one wins. Each clears the queue.
- Wrap-around:
  - Pointers wrap modulo DEPTH.
  - fetch_pc wraps modulo 2^32.
  - imem_address silently aliases modulo 2^ADDR_W; no error flag.
- Outputs are registered or derived directly from the head entry, with no combinational path from stall or redirect to the out_* signals.
- out_instruction and out_pc hold stable while stall=1.

Decomposition:
- Shared package if_pkg:
  - INSTR_W=32
  - PC_STEP=32'd4
  - NOP_INSTR=32'h0000_0000
  - typedef fetch_entry_t = struct {pc[31:0], instr[31:0]}
- One sub-module, if_entry_fifo:
  - Synchronous FIFO of fetch_entry_t, parameter DEPTH.
  - push, pop, flush, count, head data.
  - Same clk/reset.
- if_prefetch_queue owns fetch_pc, push/pop/redirect arbitration and the NOP output gating.

Test Plan:
1. Reset then free-run: hold reset=0 for 3 cycles, release, stall=0, imem preloaded with distinct words at 0,4,8,…
   -> out_valid rises 1 cycle after release with out_pc=0, then 4, 8, 12 on consecutive cycles; out_pc_plus_4 = out_pc+4.
2. Fill under stall: stall=1 from release.
   -> queue_count goes 1,2,3,4 and then holds at 4; imem_address holds at 16; out_pc stays 0.
   -> Release stall: out_pc advances 0,4,8,… with no gap or duplicate.
3. Full plus pop: with count=4, pulse stall=0 for one cycle.
   -> count stays 4, fetch_pc advances by 4, head becomes PC 4.
4. Redirect: while streaming, redirect_valid=1 with redirect_pc=32'h0000_0043.
   -> Next cycle: count=0, out_valid=0, out_instruction=0, imem_address=8'h40.
   -> Following cycle: out_pc=32'h40.
   -> Same result when stall=1 during the redirect.
5. Wrap: RESET_PC=32'hFFFF_FFF8, stall=0.
   -> out_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus_4 for FFFF_FFFC is 0; imem_address goes F8, FC, 00.
6. Reset mid-run: assert reset=0 for one edge with count=3.
   -> Next cycle: count=0, out_valid=0, imem_address=RESET_PC[7:0].
   -> First output after release is RESET_PC.
